// File: rtl/ram_sdp_fifo_ctrl.sv
// rtl/ram_sdp_fifo_ctrl.sv - FWFT FIFO controller driving a registered-read simple dual-port RAM
// Optional almost-full/almost-empty outputs are enabled by defining RAM_FIFO_ALMOST_FLAGS_EN.
module ram_sdp_fifo_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int CW     = 11,
    parameter int AF_LVL = 1020,
    parameter int AE_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_write_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_re,
    output logic [AW-1:0] ram_read_addr,
    input  logic [DW-1:0] ram_dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    ,
    output logic          almost_full,
    output logic          almost_empty
`endif
);

    localparam logic [AW:0] MEM_FULL = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   mem_cnt;
    logic          inflight;
    logic [1:0]    occ;
    logic [DW-1:0] buf_tail;
    logic          push;
    logic          pop;
    logic [2:0]    buf_need;
    logic [1:0]    tail_idx;
    logic [CW-1:0] count_next;

    assign full           = (mem_cnt == MEM_FULL);
    assign empty          = (count == '0);
    assign wr_ready       = !rst && !full;
    assign push           = wr_valid && wr_ready;
    assign ram_we         = push;
    assign ram_write_addr = wptr;
    assign ram_din        = wr_data;

    assign rd_valid       = (occ != 2'd0);
    assign pop            = rd_valid && rd_ready;
    // Buffer slots already spoken for next cycle; only fetch if one stays free.
    assign buf_need       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign ram_re         = !rst && (mem_cnt != '0) && (buf_need < 3'd2);
    assign ram_read_addr  = rptr;
    assign tail_idx       = occ - {1'b0, pop};
    assign count_next     = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            count    <= '0;
            rd_data  <= '0;
            buf_tail <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (ram_re) begin
                rptr <= rptr + AW'(1);
            end
            mem_cnt  <= mem_cnt + (AW+1)'(push) - (AW+1)'(ram_re);
            inflight <= ram_re;
            occ      <= buf_need[1:0];
            count    <= count_next;
            if (pop) begin
                rd_data <= buf_tail;
            end
            // RAM word lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (tail_idx == 2'd0) begin
                    rd_data <= ram_dout;
                end else begin
                    buf_tail <= ram_dout;
                end
            end
        end
    end

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= CW'(AF_LVL));
            almost_empty <= (count_next <= CW'(AE_LVL));
        end
    end
`else
    // Thresholds have no effect without the flag outputs.
    if (AE_LVL > AF_LVL) begin : g_unused_levels
    end
`endif

endmodule

// File: tb/tb_ram_sdp_fifo_ctrl.sv
// tb/tb_ram_sdp_fifo_ctrl.sv - directed/random self-checking bench for ram_sdp_fifo_ctrl with a RAM model
module tb_ram_sdp_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int CW    = 11;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_din;
    logic          ram_re;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_dout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    ram_sdp_fifo_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .ram_we         (ram_we),
        .ram_write_addr (ram_write_addr),
        .ram_din        (ram_din),
        .ram_re         (ram_re),
        .ram_read_addr  (ram_read_addr),
        .ram_dout       (ram_dout),
        .count          (count),
        .full           (full),
        .empty          (empty)
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full    (almost_full),
        .almost_empty   (almost_empty)
`endif
    );

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_write_addr] <= ram_din;
        if (ram_re) ram_dout <= ram[ram_read_addr];
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    int            n_in = 0;
    int            n_out = 0;
    logic          acc;
    logic          seen_valid, seen_wr_ready, seen_ram_re, seen_full, seen_empty;
    logic          seen_af, seen_ae;
    logic [CW-1:0] seen_count;
    logic [DW-1:0] last_pop;
    int            mcnt = 0;
    int            bad_re = 0;
    int            bad_we = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, score pops, then move past the edge.
    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk);
        acc           = 1'b0;
        seen_valid    = rd_valid;
        seen_wr_ready = wr_ready;
        seen_ram_re   = ram_re;
        seen_count    = count;
        seen_full     = full;
        seen_empty    = empty;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        seen_af       = almost_full;
        seen_ae       = almost_empty;
`else
        seen_af       = 1'b0;
        seen_ae       = 1'b0;
`endif
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                sb.push_back(wr_data);
                n_in++;
                acc = 1'b1;
            end
            if (rd_valid && rd_ready) begin
                n_out++;
                last_pop = rd_data;
                check("pop_has_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
        end else begin
            if (ram_re && mcnt == 0) bad_re++;
            if (ram_we != (wr_valid && wr_ready)) bad_we++;
            mcnt = mcnt + int'(ram_we) - int'(ram_re);
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end

    initial begin
        int nxt, base_in, base_out, bubbles, cbad, nacc;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h1234_5678;
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        check("rst_almost_full", almost_full, 0);
        check("rst_almost_empty", almost_empty, 1);
`endif
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;

        // Single word latency
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        cycle();
        check("t2_accept", acc, 1);
        wr_valid = 1'b0;
        cycle();
        check("t2_lat1", seen_valid, 0);
        check("t2_count1", seen_count, 1);
        cycle();
        check("t2_lat2", seen_valid, 0);
        cycle();
        check("t2_lat3", seen_valid, 1);
        check("t2_data", last_pop, 32'hDEAD_BEEF);
        cycle();
        check("t2_count", seen_count, 0);
        check("t2_empty", seen_empty, 1);

        // Fill to capacity, then drain
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        nxt = 0;
        for (int i = 0; i < 1100; i++) begin
            wr_data = DW'(nxt);
            cycle();
            if (acc) nxt++;
        end
        check("t3_accepted", nxt, 1026);
        check("t3_full", seen_full, 1);
        check("t3_wr_ready", seen_wr_ready, 0);
        check("t3_count", seen_count, 1026);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        base_out = n_out;
        cycle();
        check("t3_first_re", seen_ram_re, 1);
        check("t3_wr_ready_d0", seen_wr_ready, 0);
        cycle();
        check("t3_wr_ready_d1", seen_wr_ready, 1);
        for (int i = 0; i < 1200 && sb.size() > 0; i++) cycle();
        check("t3_drained", n_out - base_out, 1026);
        cycle();
        check("t3_empty", seen_empty, 1);

        // Streaming, pointers wrap
        base_out = n_out;
        bubbles  = 0;
        cbad     = 0;
        nacc     = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_data = 32'hA000_0000 | DW'(i);
            cycle();
            if (acc) nacc++;
            if (i >= 3 && !seen_valid) bubbles++;
            if (i >= 3 && seen_count != 3) cbad++;
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
        check("t4_accepted", nacc, 3000);
        check("t4_bubbles", bubbles, 0);
        check("t4_count_steady", cbad, 0);
        check("t4_read", n_out - base_out, 3000);

        // Random traffic
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 40000 && (n_in - base_in) < 5000; i++) begin
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_data  = $urandom;
            rd_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 1200 && sb.size() > 0; i++) cycle();
        check("t5_in", n_in - base_in, 5000);
        check("t5_out", n_out - base_out, 5000);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_bad_re", bad_re, 0);
        check("t5_bad_we", bad_we, 0);

        // Reset with a read outstanding
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        base_in  = n_in;
        for (int i = 0; i < 600 && (n_in - base_in) < 500; i++) begin
            wr_data = 32'h5000_0000 | DW'(i);
            cycle();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        cycle();
        check("t6_count", seen_count, 500);
        check("t6_read_issued", seen_ram_re, 1);
        rst      = 1'b1;
        rd_ready = 1'b0;
        cycle();
        check("t6_rst_ram_re", seen_ram_re, 0);
        check("t6_rst_wr_ready", seen_wr_ready, 0);
        sb.delete();
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'h0000_0001;
        rd_ready = 1'b1;
        base_out = n_out;
        cycle();
        check("t6_post_count", seen_count, 0);
        check("t6_post_valid", seen_valid, 0);
        check("t6_post_accept", acc, 1);
        wr_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) cycle();
        check("t6_one_read", n_out - base_out, 1);
        check("t6_first_word", last_pop, 32'h0000_0001);
        cycle();
        check("t6_empty", seen_empty, 1);

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        nacc     = 0;
        for (int i = 0; i < 1100 && nacc < 1020; i++) begin
            wr_data = DW'(i);
            cycle();
            if (acc) nacc++;
            if (seen_count == 1019) check("af_1019", seen_af, 0);
        end
        wr_valid = 1'b0;
        cycle();
        check("af_count", seen_count, 1020);
        check("af_1020", seen_af, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 1100 && seen_count > 4; i++) begin
            cycle();
            if (seen_count == 5) check("ae_5", seen_ae, 0);
        end
        check("ae_count", seen_count, 4);
        check("ae_4", seen_ae, 1);
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
